// File: rtl/pme_pkg.sv
// Shared types and defaults for the PME message transmit path.
// The retry behaviour is selected with the PME_RETRY_EN macro.
package pme_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } pme_state_t;

  localparam int unsigned PME_NUM_SRC     = 4;
  localparam int unsigned PME_TIMEOUT_CYC = 1000000;
  localparam int unsigned PME_CNT_W       = 20;

endpackage

// File: rtl/pme_msg_tx_if.sv
// PM_PME message request/ack handshake towards the link message arbiter.
interface pme_msg_tx_if
  import pme_pkg::*;
#(
  parameter int unsigned NUM_SRC = PME_NUM_SRC
);

  logic               msg_req_o;
  logic [NUM_SRC-1:0] msg_src_o;
  logic               msg_ack_i;

  modport master (output msg_req_o, output msg_src_o, input msg_ack_i);
  modport slave  (input msg_req_o, input msg_src_o, output msg_ack_i);

endinterface

// File: rtl/pme_timeout_cnt.sv
// Saturating resend timer for the PME WAIT state; only compiled with PME_RETRY_EN.
`ifdef PME_RETRY_EN
module pme_timeout_cnt
  import pme_pkg::*;
#(
  parameter int unsigned CNT_W = PME_CNT_W,
  parameter int unsigned LIMIT = PME_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // Holds at LAST so the count can never wrap back to a short timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done_c = (cnt == LAST);

endmodule
`endif

// File: rtl/pme_msg_tx.sv
// PME transmit side: sticky per-source wake status and one PM_PME request per episode.
// Define PME_RETRY_EN to resend while status stays set for TIMEOUT_CYC cycles after an ack.
module pme_msg_tx
  import pme_pkg::*;
#(
  parameter int unsigned NUM_SRC     = PME_NUM_SRC,
  parameter int unsigned TIMEOUT_CYC = PME_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = PME_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pme_en_i,
  input  logic [NUM_SRC-1:0] pme_src_i,
  input  logic               pme_clr_i,
  input  logic               link_up_i,
  output logic               pme_status_o,
  output logic [NUM_SRC-1:0] pme_pend_o,
  pme_msg_tx_if.master       msg
);

  if ((TIMEOUT_CYC < 2) || (CNT_W > 32) ||
      ((64'(1) << CNT_W) <= 64'(TIMEOUT_CYC))) begin : g_bad_cfg
    $error("pme_msg_tx: CNT_W too narrow for TIMEOUT_CYC");
  end

  pme_state_t         state;
  logic [NUM_SRC-1:0] pend_nxt_c;
  logic               timeout_c;
  logic               ack_hs_c;
  logic               in_wait_c;

  // Set wins over a same-cycle software clear.
  assign pend_nxt_c = (pme_pend_o & ~{NUM_SRC{pme_clr_i}}) | pme_src_i;

  // Status tracks the pending vector in the same cycle so the FSM sees it one edge after the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pme_pend_o   <= '0;
      pme_status_o <= 1'b0;
    end else begin
      pme_pend_o   <= pend_nxt_c;
      pme_status_o <= |pend_nxt_c;
    end
  end

  assign ack_hs_c  = (state == REQ) && msg.msg_ack_i;
  assign in_wait_c = (state == WAIT);

`ifdef PME_RETRY_EN
  pme_timeout_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (ack_hs_c),
    .en     (in_wait_c),
    .done_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Request FSM; link loss never withdraws a request already on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      msg.msg_req_o <= 1'b0;
      msg.msg_src_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pme_status_o && pme_en_i && link_up_i) begin
            state         <= REQ;
            msg.msg_req_o <= 1'b1;
            msg.msg_src_o <= pme_pend_o;
          end
        end
        REQ: begin
          if (ack_hs_c) begin
            state         <= WAIT;
            msg.msg_req_o <= 1'b0;
          end
        end
        WAIT: begin
          if (!pme_status_o || !pme_en_i) begin
            state <= IDLE;
          end else if (timeout_c && in_wait_c) begin
            state         <= REQ;
            msg.msg_req_o <= 1'b1;
            msg.msg_src_o <= pme_pend_o;
          end
        end
        default: begin
          state         <= IDLE;
          msg.msg_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
